// File: rtl/ysyx_23060062_pkg.sv
// rtl/ysyx_23060062_pkg.sv - shared types and constants for the IFU prefetch slice
package ysyx_23060062_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam int          ILEN             = 32;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ysyx_23060062_ifu_prefetch_if.sv
// rtl/ysyx_23060062_ifu_prefetch_if.sv - memory fetch port and decode-side instruction port
interface ysyx_23060062_ifu_prefetch_if
  import ysyx_23060062_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) ();
  logic             mem_read;
  logic [XLEN-1:0]  mem_addr;
  logic             mem_ready;
  logic             mem_rvalid;
  logic [ILEN-1:0]  mem_rdata;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             inst_valid;
  logic [ILEN-1:0]  inst;
  logic [XLEN-1:0]  inst_pc;
  logic             inst_ready;

  modport master (
    output mem_read, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ready, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_read, mem_addr, inst_valid, inst, inst_pc,
    output mem_ready, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ysyx_23060062_ifu_fifo.sv
// rtl/ysyx_23060062_ifu_fifo.sv - prefetch buffer; flush wins over push and pop
module ysyx_23060062_ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + AW'(1);
      if (i_pop)  r_head <= r_head + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/ysyx_23060062_ifu_prefetch.sv
// rtl/ysyx_23060062_ifu_prefetch.sv - single-outstanding instruction prefetcher with redirect flush
module ysyx_23060062_ifu_prefetch
  import ysyx_23060062_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input logic                             clk,
  input logic                             rst,
  ysyx_23060062_ifu_prefetch_if.master    bus
);
  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e          r_state;
  logic [XLEN-1:0]       r_fetch_pc;

  logic                  w_mem_read;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_inst_valid;
  logic [CW-1:0]         w_count;
  logic [XLEN+ILEN-1:0]  w_head;
  logic [XLEN-1:0]       w_req_pc;
  logic [XLEN-1:0]       w_redirect_pc;

  // Outputs held low through reset; otherwise driven purely from registered state.
  assign w_mem_read    = !rst && (r_state == ST_REQ) && (w_count < FULL);
  assign w_accept      = w_mem_read && bus.mem_ready;
  assign w_inst_valid  = !rst && (w_count != '0);
  assign w_pop         = w_inst_valid && bus.inst_ready && !bus.redirect;
  assign w_push        = !rst && !bus.redirect && (r_state == ST_WAIT) && bus.mem_rvalid;
  // fetch_pc already advanced past the outstanding request.
  assign w_req_pc      = r_fetch_pc - XLEN'(4);
  assign w_redirect_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  ysyx_23060062_ifu_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({w_req_pc, bus.mem_rdata}),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_REQ;
      r_fetch_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_fetch_pc <= w_redirect_pc;
      case (r_state)
        ST_REQ:  r_state <= w_accept ? ST_DISCARD : ST_REQ;
        default: r_state <= bus.mem_rvalid ? ST_REQ : ST_DISCARD;
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT, ST_DISCARD: begin
          if (bus.mem_rvalid) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  assign bus.mem_read   = w_mem_read;
  assign bus.mem_addr   = r_fetch_pc;
  assign bus.inst_valid = w_inst_valid;
  assign bus.inst       = w_head[ILEN-1:0];
  assign bus.inst_pc    = w_head[XLEN+ILEN-1:ILEN];

endmodule

// File: tb/tb_ysyx_23060062_ifu_prefetch.sv
// tb/tb_ysyx_23060062_ifu_prefetch.sv - scoreboard bench for the IFU prefetcher
module tb_ysyx_23060062_ifu_prefetch;
  logic clk;
  logic rst;

  ysyx_23060062_ifu_prefetch_if #(.XLEN(32)) bif ();
  ysyx_23060062_ifu_prefetch_if #(.XLEN(32)) bif2 ();

  ysyx_23060062_ifu_prefetch #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  ysyx_23060062_ifu_prefetch #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)
  ) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bif2.master)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_pops = 0;

  logic [63:0] q[$];
  logic [31:0] acc_log[$];
  logic [31:0] log2[$];
  int          acc_tok = 0;
  logic        m_pend = 0;
  logic        m_pend_ok = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] exp_pc = 32'h8000_0000;

  bit          rand_mode = 0;
  int          lat_cfg = 0;
  int          handled = 0;
  bit          r_pend = 0;
  int          r_cnt = 0;
  logic [31:0] r_addr = 0;
  logic        acc2 = 0;
  logic [31:0] a;

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] ad);
    return {ad[15:0], ~ad[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(output logic [31:0] ad);
    int k;
    k = 0;
    @(negedge clk);
    while (!(bif.mem_read && bif.mem_ready) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("accept_seen", bif.mem_read && bif.mem_ready, 1);
    ad = bif.mem_addr;
  endtask

  // Reference model: observes each cycle before the edge that acts on it.
  always @(negedge clk) begin
    logic m_acc, m_pop;
    if (rst) begin
      chk("rst_mem_read", bif.mem_read, 0);
      chk("rst_inst_valid", bif.inst_valid, 0);
      q.delete();
      m_pend = 0;
      m_pend_ok = 0;
      exp_pc = 32'h8000_0000;
    end else begin
      m_acc = bif.mem_read && bif.mem_ready;
      m_pop = bif.inst_valid && bif.inst_ready && !bif.redirect;
      chk("inst_valid", bif.inst_valid, q.size() != 0);
      if (q.size() != 0) chk("head", {bif.inst_pc, bif.inst}, q[0]);
      if (bif.mem_read) chk("mem_addr", bif.mem_addr, exp_pc);
      if (q.size() == 4) chk("full_no_read", bif.mem_read, 0);
      if (m_acc) chk("one_outstanding", m_pend, 0);
      if (bif.redirect) begin
        q.delete();
      end else begin
        if (m_pop && q.size() != 0) begin
          void'(q.pop_front());
          n_pops++;
        end
        if (bif.mem_rvalid && m_pend && m_pend_ok) q.push_back({m_addr, mem_word(m_addr)});
      end
      if (bif.mem_rvalid) m_pend = 0;
      if (m_acc) begin
        m_pend = 1;
        m_pend_ok = 1;
        m_addr = bif.mem_addr;
        exp_pc = exp_pc + 32'd4;
        acc_log.push_back(bif.mem_addr);
        acc_tok++;
      end
      if (bif.redirect) begin
        m_pend_ok = 0;
        exp_pc = {bif.redirect_pc[31:2], 2'b00};
      end
    end
  end

  // Memory responder: one response per accepted request, never for pre-reset requests.
  always @(posedge clk) begin
    #2;
    bif.mem_rvalid = 0;
    if (rst) begin
      r_pend = 0;
      handled = acc_tok;
    end else begin
      if (handled != acc_tok) begin
        handled = acc_tok;
        r_pend = 1;
        r_addr = acc_log[$];
        r_cnt = rand_mode ? int'($urandom_range(0, 3)) : lat_cfg;
      end
      if (r_pend) begin
        if (r_cnt == 0) begin
          bif.mem_rvalid = 1;
          bif.mem_rdata = mem_word(r_addr);
          r_pend = 0;
        end else begin
          r_cnt--;
        end
      end else if (rand_mode && $urandom_range(0, 7) == 0) begin
        bif.mem_rvalid = 1;
        bif.mem_rdata = $urandom;
      end
    end
  end

  always @(negedge clk) begin
    acc2 = bif2.mem_read && bif2.mem_ready;
    if (acc2 && !rst) log2.push_back(bif2.mem_addr);
  end

  always @(posedge clk) begin
    #2;
    bif2.mem_rvalid = acc2 && !rst;
    bif2.mem_rdata = 32'h0000_0013;
  end

  initial begin
    #500000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    bif.mem_ready = 0;
    bif.inst_ready = 0;
    bif.redirect = 0;
    bif.redirect_pc = 0;
    bif2.mem_ready = 1;
    bif2.inst_ready = 1;
    bif2.redirect = 0;
    bif2.redirect_pc = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_read", bif.mem_read, 0);
    rst = 0;
    bif.mem_ready = 1;
    bif.inst_ready = 1;
    #1;
    chk("first_req_valid", bif.mem_read, 1);
    chk("first_req_addr", bif.mem_addr, 32'h8000_0000);

    // Straight-line fetch with one-cycle response latency.
    repeat (10) @(posedge clk);
    #1;
    chk("seq_addr0", acc_log[0], 32'h8000_0000);
    chk("seq_addr1", acc_log[1], 32'h8000_0004);
    chk("seq_addr2", acc_log[2], 32'h8000_0008);
    chk("seq_popped", n_pops >= 3, 1);

    // Fill with decode stalled, then a single pop.
    bif.inst_ready = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("fill_len", q.size(), 4);
    chk("full_mem_read", bif.mem_read, 0);
    chk("full_inst_valid", bif.inst_valid, 1);
    bif.inst_ready = 1;
    @(posedge clk);
    #1;
    bif.inst_ready = 0;
    chk("after_pop_len", q.size(), 3);
    chk("after_pop_read", bif.mem_read, 1);
    bif.inst_ready = 1;

    // Redirect while waiting on a slow response.
    lat_cfg = 3;
    wait_accept(a);
    @(posedge clk);
    #1;
    bif.redirect = 1;
    bif.redirect_pc = 32'h8000_0100;
    @(posedge clk);
    #1;
    bif.redirect = 0;
    chk("discard_valid", bif.inst_valid, 0);
    chk("discard_read", bif.mem_read, 0);
    wait_accept(a);
    chk("redir_wait_addr", a, 32'h8000_0100);
    chk("redir_wait_empty", bif.inst_valid, 0);

    // Redirect in the same cycle as the response.
    lat_cfg = 0;
    wait_accept(a);
    @(posedge clk);
    #3;
    chk("resp_now", bif.mem_rvalid, 1);
    bif.redirect = 1;
    bif.redirect_pc = 32'h8000_0202;
    @(posedge clk);
    #1;
    bif.redirect = 0;
    wait_accept(a);
    chk("redir_resp_addr", a, 32'h8000_0200);
    chk("redir_resp_empty", bif.inst_valid, 0);

    // Redirect in the same cycle as an accept.
    lat_cfg = 2;
    @(posedge clk);
    #1;
    bif.mem_ready = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_req", bif.mem_read, 1);
    bif.mem_ready = 1;
    bif.redirect = 1;
    bif.redirect_pc = 32'h8000_0300;
    @(posedge clk);
    #1;
    bif.redirect = 0;
    chk("acc_redir_read", bif.mem_read, 0);
    wait_accept(a);
    chk("acc_redir_addr", a, 32'h8000_0300);

    // Random stalls, redirects and one mid-run reset.
    @(posedge clk);
    #1;
    rand_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      bif.mem_ready = ($urandom_range(0, 3) != 0);
      bif.inst_ready = ($urandom_range(0, 2) != 0);
      bif.redirect = ($urandom_range(0, 19) == 0);
      bif.redirect_pc = $urandom;
      rst = (i >= 700 && i < 702);
      @(posedge clk);
      #1;
    end
    rand_mode = 0;
    rst = 0;
    bif.redirect = 0;
    bif.mem_ready = 1;
    bif.inst_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("random_progress", n_pops > 100, 1);

    chk("wrap_addr0", log2[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", log2[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", log2[2], 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_23060062_ifu_prefetch.md
YSYX_23060062_IFU_PREFETCH -- requirements
Module: ysyx_23060062_ifu_prefetch

Interface
REQ-001 Parameter XLEN, default 32, width of PC and memory address.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries; legal values are powers of two, 2..16.
REQ-003 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mem_read  out  1  fetch request valid.
REQ-007 mem_addr  out  XLEN  fetch address; bits [1:0] always 0.
REQ-008 mem_ready  in  1  memory accepts the request this cycle.
REQ-009 mem_rvalid  in  1  fetch response valid.
REQ-010 mem_rdata  in  32  fetched instruction.
REQ-011 redirect  in  1  flush and restart fetch; driven by branch, jump or trap.
REQ-012 redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and treated as 0.
REQ-013 inst_valid  out  1  buffer head is valid.
REQ-014 inst  out  32  head instruction.
REQ-015 inst_pc  out  XLEN  PC of the head instruction.
REQ-016 inst_ready  in  1  decode consumes the head.

Function
REQ-017 At most one memory request is outstanding at any time; accept occurs when mem_read && mem_ready.
REQ-018 The FSM has exactly three states:
- REQ: issue a fetch.
- WAIT: a request is accepted, awaiting its response.
- DISCARD: an accepted request was invalidated by redirect.
REQ-019 In REQ, mem_read=1 iff buffer count < DEPTH; mem_read depends on registered state only, with no combinational path from any input.
REQ-020 While mem_read=1 and not accepted, mem_addr holds fetch_pc unchanged.
REQ-021 On accept, fetch_pc advances by 4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0) and the FSM goes REQ->WAIT.
REQ-022 In WAIT with mem_rvalid, the module pushes {pc of the request, mem_rdata} into the buffer and returns to REQ.
REQ-023 In DISCARD with mem_rvalid, the response is dropped and the FSM goes to REQ.
REQ-024 mem_rvalid in REQ is ignored.
REQ-025 A redirect clears the buffer (count=0) and loads fetch_pc from redirect_pc.
- REQ state: if the same cycle accepts a request, go to DISCARD; otherwise stay in REQ.
- WAIT state: without mem_rvalid, go to DISCARD; with mem_rvalid, drop the response and go to REQ.
- DISCARD state: without mem_rvalid, stay in DISCARD; with mem_rvalid, go to REQ.
REQ-026 redirect has priority over push and pop in the same cycle; an inst_ready handshake in a redirect cycle is not a pop.
REQ-027 inst_valid = (count != 0); inst and inst_pc come from the registered head entry with no bypass. A response in cycle N into an empty buffer gives inst_valid=1 in cycle N+1.
REQ-028 A pop occurs when inst_valid && inst_ready; the head pointer advances modulo DEPTH.
REQ-029 Push and pop in the same cycle leave count unchanged, including at count=DEPTH-1 and count=1.
REQ-030 Count never exceeds DEPTH, because a request is issued only when count < DEPTH.
REQ-031 inst and inst_pc are stable while inst_valid && !inst_ready and no redirect occurs.

Reset
REQ-032 While rst=1 at a clock edge:
- state=REQ, fetch_pc=RESET_PC.
- count=0, head and tail pointers = 0.
- Buffer data need not be reset.
REQ-033 mem_read=0 and inst_valid=0 in every cycle in which rst=1.
REQ-034 The first request, addr=RESET_PC, appears in the first cycle after rst deasserts.
REQ-035 Reset mid-WAIT or mid-DISCARD discards the pending transaction; the memory side shares rst and returns no response for pre-reset requests.

Structure
REQ-036 Package ysyx_23060062_pkg holds:
- FSM state enum (REQ/WAIT/DISCARD).
- Default XLEN and RESET_PC constants.
- ILEN=32 constant.
REQ-037 The buffer is sub-module ysyx_23060062_ifu_fifo, parametrised by data width and DEPTH, with push, pop and flush inputs and a count output; flush has priority.
REQ-038 The FSM and fetch_pc live in the top module; no latches and no multi-driven state.

Verification
REQ-039 Reset release, mem_ready=1, one-cycle response latency, inst_ready=1 -> requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; inst_pc sequence matches with inst = mem_rdata.
REQ-040 inst_ready=0, DEPTH=4 -> exactly 4 entries fill and mem_read stays 0. Then inst_ready=1 for one cycle -> one pop, and mem_read=1 in the next cycle.
REQ-041 Redirect to 0x8000_0100 while in WAIT, response arrives 3 cycles later -> that response is dropped, buffer is empty, and the next request has addr=0x8000_0100.
REQ-042 Redirect coincides with mem_rvalid in WAIT, and separately with an accept in REQ -> response dropped and REQ resumes at redirect_pc; accepted request discarded via DISCARD.
REQ-043 RESET_PC=32'hFFFF_FFF8 -> request addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-044 Random mem_ready/mem_rvalid stalls plus random redirect against a reference queue model -> popped {inst_pc, inst} sequence matches, and at most one request is outstanding.
